// File: rtl/gf2m_serial_multiplier.sv
// Digit-serial GF(2^M) multiplier: MSB-first shift-reduce over operand b, DIGIT bits per cycle.
// Handshaked operand/result ports; an optional squaring mode reuses a as the multiplier.
module gf2m_serial_multiplier #(
    parameter int         M     = 8,
    parameter logic [M:0] POLY  = 9'h11B,
    parameter int         DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  logic         op_sq,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] result,
    output logic         busy
);

    localparam int STEPS = M / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state;
    logic [M-1:0]  a_q;
    logic [M-1:0]  b_q;
    logic [M-1:0]  acc;
    logic [M-1:0]  acc_next;
    logic [CW-1:0] cnt;

    // Multiply by x and reduce modulo POLY, keeping the value at M bits.
    function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY[M-1:0] : '0);
    endfunction

    // Horner over the current digit (b_q's top DIGIT bits), one reduced shift per bit.
    always_comb begin
        // NOTE: blocking assignments here chain the per-bit steps within one cycle;
        // the default first keeps the block free of inferred latches.
        acc_next = acc;
        for (int i = DIGIT - 1; i >= 0; i--) begin
            acc_next = xtime(acc_next) ^ (b_q[M - DIGIT + i] ? a_q : '0);
        end
    end

    // Held low during reset so no operand can be offered while the block is being cleared.
    assign in_ready = rst_n && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are cleared too, so an aborted operation
            // leaves nothing behind that could leak into the next result.
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= op_sq ? a : b;
                        acc   <= '0;
                        cnt   <= CW'(STEPS);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    b_q <= b_q << DIGIT;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result    <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gf2m_serial_multiplier.md
GF2M_SERIAL_MULTIPLIER -- requirements
Module: gf2m_serial_multiplier

Interface
REQ-001 Parameter M, default 8: field degree and operand/result width in bits.
REQ-002 Parameter POLY, default 9'h11B: irreducible field polynomial, M+1 bits wide, with bit M set.
REQ-003 Parameter DIGIT, default 1: operand-b bits consumed per compute cycle; M mod DIGIT SHALL be 0.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand set presented.
REQ-007 in_ready  output  1  block can accept an operand set.
REQ-008 a  input  M  multiplicand.
REQ-009 b  input  M  multiplier; ignored when op_sq=1.
REQ-010 op_sq  input  1  0 = a·b mod POLY; 1 = a·a mod POLY.
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 result  output  M  product in GF(2^M).
REQ-014 busy  output  1  high in CALC or DONE.

Function
REQ-015 FSM states SHALL be IDLE, CALC and DONE.
REQ-016 IDLE: in_ready=1; on in_valid=1 the block SHALL latch a, the effective b (a when op_sq=1), and clear the accumulator, then move to CALC.
REQ-017 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE SHALL be ignored.
REQ-018 CALC SHALL process b MSB-first, DIGIT bits per cycle: acc = (acc·x^DIGIT mod POLY) XOR (a·digit mod POLY).
REQ-019 Every intermediate value SHALL be fully reduced to M bits each cycle; no wider partial products shall be stored.
REQ-020 CALC SHALL last exactly M/DIGIT cycles, tracked by a digit counter of width ceil(log2(M/DIGIT+1)).
REQ-021 out_valid SHALL rise exactly M/DIGIT cycles after the accepting edge, independent of operand values, including zero operands.
REQ-022 DONE: out_valid=1; result and out_valid SHALL hold stable until out_ready=1.
REQ-023 DONE with out_ready=1: the FSM SHALL return to IDLE on that edge; a new operand SHALL NOT be accepted on the same edge.
REQ-024 The minimum issue interval SHALL be M/DIGIT+2 cycles (accept edge, compute edges, handshake edge).
REQ-025 result SHALL retain the last product in IDLE until the next computation completes.
REQ-026 Operand inputs SHALL be sampled only on the accepting edge; changes during CALC SHALL have no effect.
REQ-027 The datapath SHALL be purely XOR/AND shift-reduce, with no multipliers or lookup tables.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, out_valid=0, busy=0, result=0, accumulator=0 and counter=0.
REQ-029 in_ready SHALL be 0 while rst_n=0 and 1 on the first cycle after release.
REQ-030 Reset asserted during CALC or DONE SHALL abort the operation with no output pulse; the aborted operand set SHALL be discarded.

Verification
REQ-031 Default parameters, a=0x57, b=0x83, op_sq=0 -> result=0xC1, with out_valid exactly 8 cycles after accept.
REQ-032 Default parameters, a=0x53, b=0xCA -> 0x01; a=0x80, b=0x02 -> 0x1B; op_sq=1 with a=0x03 and b=0xFF -> 0x05.
REQ-033 M=4, POLY=5'h13, DIGIT=2, a=0x7, b=0x9 -> result=0xA after 2 compute cycles; a=0, b=0xF -> 0x0 with the same latency.
REQ-034 Back-pressure: out_ready held 0 for 5 cycles in DONE -> result/out_valid stable, in_ready=0 and in_valid pulses ignored; release -> IDLE next edge.
REQ-035 rst_n pulsed low at CALC cycle 4 -> out_valid never asserts, result=0; the next operation after release completes correctly.
REQ-036 A random regression of at least 10k operand pairs across DIGIT values {1,2,4,8} SHALL match a bitwise software GF(2^8) reference model.
